vram_arbiter: RTL
=================

# vram_arbiter

Single-port video RAM arbiter sharing one synchronous-read frame buffer between the VGA scan-out pixel fetch and a host drawing port. Display fetches have absolute priority; host accesses fill the idle RAM cycles under a req/ack handshake. The block sits between the VGA timing/pixel path and the frame-buffer BRAM; it sequences every RAM access and routes read data back to its owner through a return-tag pipeline.

## Interface
- ADDR_W, 15, frame-buffer address width (160x120 bytes fits)
- DATA_W, 8, pixel width (packed {blue[1:0], green[2:0], red[2:0]})
- One clock `clk`; reset `rst` is asynchronous and active-high. All state clears on `rst` assertion, independent of `clk`.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- disp_req  in  1  display requests one pixel read this cycle
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  returned pixel
- disp_valid  out  1  disp_data valid, one-cycle pulse
- host_req  in  1  host access request; held until host_ack
- host_addr  in  ADDR_W  host address; stable while host_req
- host_wdata  in  DATA_W  host write data; stable while host_req
- host_we  in  1  1 = write, 0 = read (present only with VRAM_ARB_HOST_RD_EN)
- host_rdata  out  DATA_W  host read data (present only with VRAM_ARB_HOST_RD_EN)
- host_ack  out  1  one-cycle completion pulse
- ram_en, ram_we  out  1  registered RAM enable / write enable
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0

## Operation
- Decision each cycle T: disp_req=1 -> display granted; else host_req=1 and FSM in IDLE -> host granted; else no access.
- Granted access drives ram_* registered at T+1. Non-granted cycle: ram_en=0, ram_we=0, ram_addr/ram_wdata hold.
- Display is never stalled; host may starve indefinitely while disp_req stays high (accepted behaviour).
- Host FSM: IDLE -> WR_ACK (write granted; host_ack=1 in T+1) -> IDLE. With reads: IDLE -> RD_ISSUE -> RD_CAPT -> RD_ACK (host_ack=1, host_rdata valid in T+3) -> IDLE.
- Outside IDLE, host_req is ignored (prevents double grant in the ack cycle). Display grants continue in every host state.
- Return-tag pipe (2 stages: NONE/DISP/HOST) follows each issued access; tag at RAM-data stage selects which output register captures ram_rdata. Write accesses carry tag NONE.
- disp_data/host_rdata hold their last captured value between pulses.
- Reset: disp_valid=0, host_ack=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_data=0, host_rdata=0, FSM=IDLE, tags=NONE. In-flight reads are discarded, no ack issued; a host_req still high after reset is re-arbitrated from scratch.

## Timing
- Display read: disp_req at T -> disp_valid at T+3. Back-to-back disp_req every cycle yields disp_valid every cycle.
- Host write: grant T -> ram_we at T+1 -> host_ack at T+1. Minimum host write spacing 2 cycles.
- Host read: grant T -> host_ack at T+3. Minimum spacing 4 cycles.
- A display grant at T+1 or T+2 of a host read does not collide: each access occupies one RAM cycle, tags keep returns ordered.
- Simultaneous disp_req and host_req at T: display wins; host granted on first cycle with disp_req=0 while FSM in IDLE.

## Configuration
- VRAM_ARB_HOST_RD_EN defined: host_we and host_rdata ports exist; RD_* states and HOST tag implemented.
- Undefined: host port is write-only, every grant is a write, FSM is IDLE/WR_ACK only, tag pipe carries DISP/NONE only.

## Structure
- Package vram_arb_pkg: ADDR_W/DATA_W defaults, FSM state encoding, tag encoding (TAG_NONE, TAG_DISP, TAG_HOST), read latency constant (2).
- Sub-module vram_arb_tag_pipe: 2-stage tag shift register with async reset to TAG_NONE.

## Test plan
- Reset mid-read: host read granted, rst pulsed at T+2 -> no host_ack, all outputs 0, host_req still high re-granted 1 cycle after rst release, ack 3 cycles later.
- Display stream: disp_req=1 for 8 cycles, addrs 0..7, RAM preloaded addr^8'h5A -> disp_valid 8 consecutive cycles from T+3, data 5A,5B,58,...
- Host write: host_req, addr 15'h0123, wdata 8'hE7, disp_req=0 -> ram_we=1 with addr 0123 and host_ack at T+1, no second write.
- Contention: disp_req high 5 cycles, host write pending -> host grant in first cycle disp_req low, ram_we never coincides with display ram_en.
- Interleave (HOST_RD_EN): host read of 0x0040 (=8'h3C) at T, disp_req at T+1 for 0x0041 (=8'hC3) -> host_ack+host_rdata=3C at T+3, disp_valid+disp_data=C3 at T+4.
- Build without VRAM_ARB_HOST_RD_EN: every host op writes, ack at T+1.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the frame-buffer arbiter.
// Optional host read path is enabled by defining VRAM_ARB_HOST_RD_EN.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;
  localparam int RD_LAT      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ACK,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_RD_ACK
  } host_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

endpackage

// File: rtl/vram_arb_tag_pipe.sv
// Return-tag shift register; the last stage lines up with RAM read data.
// Fixed RD_LAT-cycle latency, no backpressure.
module vram_arb_tag_pipe
  import vram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: display fetch has absolute priority, host fills idle cycles.
// Display read 3 cycles, host write ack at T+1, host read ack at T+3 (VRAM_ARB_HOST_RD_EN); host may starve.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef VRAM_ARB_HOST_RD_EN
  input  logic              host_we,
  output logic [DATA_W-1:0] host_rdata,
`endif
  output logic              host_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  host_state_t state, state_nxt;
  logic        host_grant;
  logic        host_wr;
  tag_t        issue_tag, ret_tag;

`ifdef VRAM_ARB_HOST_RD_EN
  assign host_wr = host_we;
`else
  assign host_wr = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    host_grant = 1'b0;
    issue_tag  = TAG_NONE;
    host_ack   = 1'b0;

    // Host is only considered from IDLE so the ack cycle cannot re-grant.
    if (!disp_req && host_req && state == ST_IDLE) host_grant = 1'b1;

    if (disp_req) issue_tag = TAG_DISP;
`ifdef VRAM_ARB_HOST_RD_EN
    else if (host_grant && !host_wr) issue_tag = TAG_HOST;
`endif

    case (state)
      ST_IDLE: begin
        if (host_grant) begin
`ifdef VRAM_ARB_HOST_RD_EN
          state_nxt = host_wr ? ST_WR_ACK : ST_RD_ISSUE;
`else
          state_nxt = ST_WR_ACK;
`endif
        end
      end
      ST_WR_ACK: begin
        host_ack  = 1'b1;
        state_nxt = ST_IDLE;
      end
`ifdef VRAM_ARB_HOST_RD_EN
      ST_RD_ISSUE: state_nxt = ST_RD_CAPT;
      ST_RD_CAPT:  state_nxt = ST_RD_ACK;
      ST_RD_ACK: begin
        host_ack  = 1'b1;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state  <= state_nxt;
      ram_en <= disp_req | host_grant;
      ram_we <= host_grant & host_wr;
      if (disp_req) begin
        ram_addr <= disp_addr;
      end else if (host_grant) begin
        ram_addr  <= host_addr;
        ram_wdata <= host_wdata;
      end
    end
  end

  vram_arb_tag_pipe u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (issue_tag),
    .tag_out (ret_tag)
  );

  // Read data is steered to whichever requester owns the access now returning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
`ifdef VRAM_ARB_HOST_RD_EN
      host_rdata <= '0;
`endif
    end else begin
      disp_valid <= (ret_tag == TAG_DISP);
      if (ret_tag == TAG_DISP) disp_data <= ram_rdata;
`ifdef VRAM_ARB_HOST_RD_EN
      if (ret_tag == TAG_HOST) host_rdata <= ram_rdata;
`endif
    end
  end

endmodule
